// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with a one-cycle expiry pulse.
// States IDLE / RUN / DONE. The remaining count decrements once per cycle
// while RUN and en=1. Expiry is reported by done=1 for the single cycle
// the FSM spends in DONE.
// Input priority within one cycle: rst > stop > load > start > en.
// Optional feature macro: DOWN_TIMER_AUTO_RELOAD_EN. When it is defined,
// DONE re-arms from the reload register, which gives a periodic done.
// The debug output `state` shows the registered FSM state
// (0=IDLE, 1=RUN, 2=DONE).
// Control inputs are level-sampled on every rising edge. There is no
// valid/ready handshake: load, start and stop act in the cycle they are
// high.
module down_timer #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            start,
  input  logic            stop,
  input  logic            en,
  output logic [SIZE-1:0] count,
  output logic            busy,
  output logic            done,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_nxt;
  logic [SIZE-1:0] count_nxt;
  logic [SIZE-1:0] reload_q;
  logic [SIZE-1:0] reload_nxt;

  // State, count and reload registers; synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count    <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_nxt;
      count    <= count_nxt;
      reload_q <= reload_nxt;
    end
  end

  // Next state and next count, applied in priority order stop > load > start > en.
  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count;
    reload_nxt = reload_q;
    unique case (state_q)
      S_IDLE: begin
        if (!stop) begin
          if (load) begin
            count_nxt  = load_val;
            reload_nxt = load_val;
          end else if (start) begin
            // A start with nothing left to count is a zero-length run.
            state_nxt = (count == '0) ? S_DONE : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (load) begin
          count_nxt  = load_val;
          reload_nxt = load_val;
          if (load_val == '0) state_nxt = S_DONE;
        end else if (en && (count != '0)) begin
          // The count != 0 guard keeps the counter from wrapping to all-ones.
          count_nxt = count - SIZE'(1);
          if (count == SIZE'(1)) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        if (!stop) begin
          if (load) begin
            count_nxt  = load_val;
            reload_nxt = load_val;
          end
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
          // Re-arm from the reload value. A load in the same cycle supplies
          // the new value directly. A reload value of 0 stays in DONE.
          if (load) begin
            state_nxt = (load_val == '0) ? S_DONE : S_RUN;
          end else begin
            count_nxt = reload_q;
            state_nxt = (reload_q == '0) ? S_DONE : S_RUN;
          end
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs, decoded only from the registered state.
  always_comb begin
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
    state = state_q;
  end

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed stimulus for down_timer. A behavioural model
// tracks the remaining count and the running/expired flags from the
// timer's rules. A compare process checks the DUT against the model on
// every falling edge. Literal expectations pin the model at key points.
module tb_down_timer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         stop;
  logic         en;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int passed;
  int total;
  bit check_on;

  // model state
  int           m_cnt;
  int           m_rel;
  bit           m_running;
  bit           m_expired;
  logic [W-1:0] exp_q[$];

  down_timer #(.SIZE(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .state    (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: applies the timer rules to the inputs sampled at each edge.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_rel = 0; m_running = 0; m_expired = 0;
    end else if (m_expired) begin
      m_expired = 0;
      if (!stop) begin
        if (load) begin m_cnt = int'(load_val); m_rel = int'(load_val); end
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        m_cnt = m_rel;
        if (m_rel == 0) m_expired = 1;
        else m_running = 1;
`endif
      end
    end else if (m_running) begin
      if (stop) m_running = 0;
      else if (load) begin
        m_cnt = int'(load_val); m_rel = int'(load_val);
        if (m_cnt == 0) begin m_running = 0; m_expired = 1; end
      end else if (en && m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_running = 0; m_expired = 1; end
      end
    end else begin
      if (stop) ;
      else if (load) begin m_cnt = int'(load_val); m_rel = int'(load_val); end
      else if (start) begin
        if (m_cnt == 0) m_expired = 1;
        else m_running = 1;
      end
    end
  end

  // Compare process: DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_on) begin
      check("model_count", 32'(count), 32'(m_cnt));
      check("model_busy", 32'(busy), 32'(m_running));
      check("model_done", 32'(done), 32'(m_expired));
    end
  end

  // Driver: apply one cycle of inputs, return after the falling edge.
  task automatic drive(input logic l, input logic [W-1:0] v, input logic s,
                       input logic sp, input logic e);
    load = l; load_val = v; start = s; stop = sp; en = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic e);
    drive(1'b0, '0, 1'b0, 1'b0, e);
  endtask

  initial begin
    logic [4:0] gate_pat;
    int pulses;
    int guard;
    logic [W-1:0] exp_v;
    passed = 0; total = 0; check_on = 1'b1;
    m_cnt = 0; m_rel = 0; m_running = 0; m_expired = 0;
    rst = 1'b1; load = 0; load_val = '0; start = 0; stop = 0; en = 0;

    // reset, then idle with en high
    idle(1'b0);
    idle(1'b0);
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    repeat (3) idle(1'b1);
    check("idle_en_count", 32'(count), 0);

    // basic run of 5
    drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
    check("load5_count", 32'(count), 5);
    check("load5_busy", 32'(busy), 0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("start5_busy", 32'(busy), 1);
    check("start5_count", 32'(count), 5);
    for (int k = 4; k >= 0; k--) exp_q.push_back(W'(k));
    while (exp_q.size() > 0) begin
      idle(1'b1);
      exp_v = exp_q.pop_front();
      check("run5_count", 32'(count), 32'(exp_v));
    end
    check("run5_done", 32'(done), 1);
    check("run5_busy", 32'(busy), 0);
    idle(1'b1);
    check("run5_after_done", 32'(done), 0);
    check("run5_after_count", 32'(count), 0);

    // gated ticks with en pattern 1,0,1,0,1
    drive(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    gate_pat = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      idle(gate_pat[4-i]);
      if (i == 1) check("gated_hold", 32'(count), 2);
    end
    check("gated_done", 32'(done), 1);
    check("gated_count", 32'(count), 0);
    idle(1'b0);
    check("gated_after_done", 32'(done), 0);

    // zero-length run
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 0);
    idle(1'b0);
    check("zero_after_done", 32'(done), 0);

    // stop after 4 ticks of a 10 run
    drive(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (4) idle(1'b1);
    check("stop_pre_count", 32'(count), 6);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("stop_busy", 32'(busy), 0);
    check("stop_count", 32'(count), 6);
    repeat (3) idle(1'b1);
    check("stop_hold_count", 32'(count), 6);
    check("stop_no_done", 32'(done), 0);

    // load and start together: load wins, stays idle
    drive(1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    check("ldst_count", 32'(count), 7);
    check("ldst_busy", 32'(busy), 0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("ldst_run_busy", 32'(busy), 1);
    check("ldst_run_count", 32'(count), 7);
    repeat (4) idle(1'b1);
    check("pre_rst_count", 32'(count), 3);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    check("midrst_count", 32'(count), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    idle(1'b1);
    check("midrst_after_done", 32'(done), 0);

    // load inside RUN, load of 0 expires, load inside DONE
    drive(1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    drive(1'b1, 8'd9, 1'b0, 1'b0, 1'b1);
    check("runload_count", 32'(count), 9);
    check("runload_busy", 32'(busy), 1);
    drive(1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    check("runload0_done", 32'(done), 1);
    drive(1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
    check("doneload_count", 32'(count), 2);
    check("doneload_done", 32'(done), 0);
`ifndef DOWN_TIMER_AUTO_RELOAD_EN
    check("doneload_idle", 32'(busy), 0);
`endif
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("cleanup_busy", 32'(busy), 0);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    // periodic done with reload value 2
    drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    pulses = 0;
    repeat (12) begin
      idle(1'b1);
      if (done) pulses++;
    end
    check("ar_pulses", 32'(pulses), 4);
    guard = 0;
    while (!done && guard < 5) begin
      idle(1'b1);
      guard++;
    end
    check("ar_done_seen", 32'(done), 1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("ar_stop_busy", 32'(busy), 0);
    check("ar_stop_done", 32'(done), 0);
    repeat (4) idle(1'b1);
    check("ar_stopped_done", 32'(done), 0);
`else
    pulses = 0;
    guard = 0;
`endif

    check_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
